// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int          XLEN_DEF    = 32;
   localparam logic [31:0] INST_FINISH = 32'h0000_0000;
   localparam int          PC_STEP     = 4;

   typedef enum logic [2:0] {
      REQ,
      WAIT,
      DROP,
      HOLD,
      HALT
   } state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to
// instruction memory, buffers the returned word and hands it to the core.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            fetch_fault,
   output logic            halted
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_d, inst_pc_d;
   logic            inst_valid_d, fault_d, halted_d;
   logic            req_v;
   logic            redir_bad;

   // A redirect to a non word-aligned target is a fault wherever it lands.
   assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

   // Request is combinational so a same-cycle redirect can suppress it;
   // held low while reset is asserted.
   assign imem_req_valid = req_v && !rst;
   assign imem_req_addr  = pc_q;

   // Next-state and next-output logic; every target defaults to hold.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst;
      inst_pc_d    = inst_pc;
      inst_valid_d = inst_valid;
      fault_d      = fetch_fault;
      halted_d     = halted;
      req_v        = 1'b0;
      if (state_q != HALT && redir_bad) begin
         // Pending response (if any) is simply never awaited.
         fault_d      = 1'b1;
         halted_d     = 1'b1;
         inst_valid_d = 1'b0;
         state_d      = HALT;
      end else begin
         unique case (state_q)
            REQ: begin
               if (redirect_valid) begin
                  pc_d = redirect_pc;
               end else begin
                  req_v = 1'b1;
                  if (imem_req_ready) state_d = WAIT;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  // Redirect wins over the response, including its error.
                  pc_d    = redirect_pc;
                  state_d = imem_rsp_valid ? REQ : DROP;
               end else if (imem_rsp_valid) begin
                  if (imem_rsp_err) begin
                     fault_d  = 1'b1;
                     halted_d = 1'b1;
                     state_d  = HALT;
                  end else begin
                     inst_d       = imem_rsp_data;
                     inst_pc_d    = pc_q;
                     inst_valid_d = 1'b1;
                     state_d      = HOLD;
                  end
               end
            end
            DROP: begin
               if (redirect_valid) pc_d = redirect_pc;
               if (imem_rsp_valid) state_d = REQ;
            end
            HOLD: begin
               if (redirect_valid) begin
                  // A same-cycle handshake still transfers; redirect sets the PC.
                  inst_valid_d = 1'b0;
                  pc_d         = redirect_pc;
                  state_d      = REQ;
               end else if (inst_ready) begin
                  inst_valid_d = 1'b0;
                  if (inst == XLEN'(INST_FINISH)) begin
                     halted_d = 1'b1;
                     state_d  = HALT;
                  end else begin
                     pc_d    = pc_q + XLEN'(PC_STEP);
                     state_d = REQ;
                  end
               end
            end
            default: begin
               inst_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs; async reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         inst        <= '0;
         inst_pc     <= '0;
         inst_valid  <= 1'b0;
         fetch_fault <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst        <= inst_d;
         inst_pc     <= inst_pc_d;
         inst_valid  <= inst_valid_d;
         fetch_fault <= fault_d;
         halted      <= halted_d;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios followed by a randomized run,
// checked against a transaction-level model of the fetch stream.
module tb_ifu_fetch;

   localparam logic [31:0] RPC  = 32'h8000_0000;
   localparam logic [31:0] WRAP = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst, inst_pc;
   logic        fetch_fault, halted;

   logic        w_req_valid, w_inst_valid, w_fault, w_halted;
   logic [31:0] w_req_addr, w_inst, w_inst_pc;

   ifu_fetch u_dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc),
      .fetch_fault(fetch_fault), .halted(halted)
   );

   // Second instance shares every input; only its reset PC differs, so its
   // request timing tracks the first instance exactly.
   ifu_fetch #(.RESET_PC(WRAP)) u_wrap (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(w_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .inst_valid(w_inst_valid), .inst_ready(inst_ready),
      .inst(w_inst), .inst_pc(w_inst_pc),
      .fetch_fault(w_fault), .halted(w_halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // memory model
   logic [31:0] mem [logic [31:0]];
   bit          m_out, m_disc;
   logic [31:0] m_addr;
   int          m_lat;
   int          lat_force = 0;
   bit          rand_rdy = 1'b0;
   bit          err_next = 1'b0;

   // fetch-stream model: next PC the core should see, and whether fetch stopped
   logic [31:0] exp_pc;
   bit          m_halt;
   int          n_deliv;

   // pre-edge samples from the last cycle
   bit          s_acc, s_wacc, s_rv, s_hs;
   logic [31:0] s_addr, s_waddr, s_inst;

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return ((a * 32'h9E37_79B1) ^ 32'h0000_0013) | 32'h1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after negedge, sample before posedge,
   // advance models at posedge, return at the next negedge.
   task automatic cyc(input bit rd, input logic [31:0] rpc, input bit ir);
      bit fire, was_halt;
      redirect_valid = rd;
      redirect_pc    = rpc;
      inst_ready     = ir;
      imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      fire           = m_out && (m_lat == 0);
      imem_rsp_valid = fire;
      imem_rsp_data  = fire ? memrd(m_addr) : 32'h0;
      imem_rsp_err   = fire && err_next;
      #1;
      s_rv    = imem_req_valid;
      s_acc   = imem_req_valid && imem_req_ready;
      s_wacc  = w_req_valid && imem_req_ready;
      s_addr  = imem_req_addr;
      s_waddr = w_req_addr;
      s_hs    = inst_valid && inst_ready;
      s_inst  = inst;
      if (s_acc) begin
         chk("req_addr", imem_req_addr, exp_pc);
         chk("one_outstanding", 32'(m_out && !fire), 32'h0);
      end
      if (s_hs) begin
         chk("inst_pc", inst_pc, exp_pc);
         chk("inst_word", inst, memrd(inst_pc));
      end
      if (m_halt) begin
         chk("halt_noreq", 32'(imem_req_valid), 32'h0);
         chk("halt_noinst", 32'(inst_valid), 32'h0);
      end
      @(posedge clk);
      was_halt = m_halt;
      if (s_hs) n_deliv++;
      if (rd && !was_halt) begin
         if (rpc[1:0] != 2'b00) m_halt = 1'b1;
         else begin
            exp_pc = rpc;
            if (m_out && !fire) m_disc = 1'b1;
         end
      end else if (s_hs) begin
         if (s_inst == 32'h0) m_halt = 1'b1;
         else exp_pc = exp_pc + 32'd4;
      end
      if (fire && err_next && !rd && !m_disc && !was_halt) m_halt = 1'b1;
      if (fire) begin
         m_out  = 1'b0;
         m_disc = 1'b0;
      end else if (m_out) m_lat--;
      if (s_acc) begin
         m_out  = 1'b1;
         m_addr = s_addr;
         m_lat  = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 2));
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      inst_ready     = 1'b0;
      m_out = 1'b0; m_disc = 1'b0; m_halt = 1'b0; err_next = 1'b0;
      exp_pc = RPC; n_deliv = 0;
      mem.delete();
      repeat (2) @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_addr", imem_req_addr, RPC);
      rst = 1'b0;
   endtask

   task automatic run_until_acc(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         cyc(1'b0, 32'h0, 1'b0);
         ok = s_acc;
      end
   endtask

   task automatic wait_iv(input int budget, output bit ok);
      ok = inst_valid;
      for (int i = 0; i < budget && !ok; i++) begin
         cyc(1'b0, 32'h0, 1'b0);
         ok = inst_valid;
      end
   endtask

   initial begin
      bit ok;

      // 1 + 5: basic fetch, stall, PC step; wrap instance rolls over to 0
      do_reset();
      lat_force = 0;
      mem[RPC]         = 32'h0010_0093;
      mem[RPC + 32'd4] = 32'h0020_0113;
      run_until_acc(8, ok);
      chk("t1_acc0_seen", 32'(ok), 32'h1);
      chk("t1_addr0", s_addr, RPC);
      chk("t5_wrap_acc0", 32'(s_wacc), 32'h1);
      chk("t5_wrap_addr0", s_waddr, WRAP);
      wait_iv(8, ok);
      chk("t1_iv0_seen", 32'(ok), 32'h1);
      chk("t1_inst0", inst, 32'h0010_0093);
      chk("t1_pc0", inst_pc, RPC);
      repeat (3) begin
         cyc(1'b0, 32'h0, 1'b0);
         chk("t1_stall_valid", 32'(inst_valid), 32'h1);
         chk("t1_stall_inst", inst, 32'h0010_0093);
      end
      cyc(1'b0, 32'h0, 1'b1);
      run_until_acc(8, ok);
      chk("t1_acc1_seen", 32'(ok), 32'h1);
      chk("t1_addr1", s_addr, RPC + 32'd4);
      chk("t5_wrap_addr1", s_waddr, 32'h0);
      wait_iv(8, ok);
      chk("t1_iv1_seen", 32'(ok), 32'h1);
      chk("t1_inst1", inst, 32'h0020_0113);
      chk("t1_pc1", inst_pc, RPC + 32'd4);
      cyc(1'b0, 32'h0, 1'b1);

      // 2: redirect while waiting; late response discarded
      do_reset();
      lat_force = 1;
      mem[RPC] = 32'hDEAD_BEEF;
      run_until_acc(8, ok);
      chk("t2_acc_seen", 32'(ok), 32'h1);
      cyc(1'b1, 32'h8000_0100, 1'b0);
      run_until_acc(8, ok);
      chk("t2_acc_redir", 32'(ok), 32'h1);
      chk("t2_addr", s_addr, 32'h8000_0100);
      wait_iv(8, ok);
      chk("t2_iv_seen", 32'(ok), 32'h1);
      chk("t2_inst_pc", inst_pc, 32'h8000_0100);
      chk("t2_inst", inst, memrd(32'h8000_0100));
      cyc(1'b0, 32'h0, 1'b1);

      // 3: zero instruction consumed halts fetch; redirects ignored
      do_reset();
      lat_force = 0;
      mem[RPC] = 32'h0;
      wait_iv(10, ok);
      chk("t3_iv_seen", 32'(ok), 32'h1);
      chk("t3_inst", inst, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      chk("t3_halted", 32'(halted), 32'h1);
      chk("t3_wrap_halted", 32'(w_halted), 32'h1);
      chk("t3_no_fault", 32'(fetch_fault), 32'h0);
      for (int i = 0; i < 20; i++) cyc(i % 3 == 0, 32'h8000_0200, 1'b1);
      chk("t3_still_halted", 32'(halted), 32'h1);

      // 4a: response error faults and halts
      do_reset();
      lat_force = 0;
      err_next  = 1'b1;
      run_until_acc(8, ok);
      chk("t4_acc_seen", 32'(ok), 32'h1);
      cyc(1'b0, 32'h0, 1'b0);
      chk("t4_err_fault", 32'(fetch_fault), 32'h1);
      chk("t4_err_halted", 32'(halted), 32'h1);
      err_next = 1'b0;
      repeat (5) cyc(1'b0, 32'h0, 1'b1);

      // 4b: misaligned redirect straight out of reset
      do_reset();
      cyc(1'b1, 32'h8000_0002, 1'b0);
      chk("t4_mis_noreq", 32'(s_rv), 32'h0);
      chk("t4_mis_fault", 32'(fetch_fault), 32'h1);
      chk("t4_mis_halted", 32'(halted), 32'h1);
      repeat (10) cyc(1'b0, 32'h0, 1'b1);

      // 6: async reset while an instruction is held
      do_reset();
      lat_force = 0;
      wait_iv(10, ok);
      chk("t6_iv_seen", 32'(ok), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_iv", 32'(inst_valid), 32'h0);
      chk("t6_async_inst", inst, 32'h0);
      chk("t6_async_pc", inst_pc, 32'h0);
      chk("t6_async_req", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
      do_reset();
      run_until_acc(8, ok);
      chk("t6_acc_seen", 32'(ok), 32'h1);
      chk("t6_addr", s_addr, RPC);

      // randomized run: redirects, stalls, variable memory latency
      do_reset();
      lat_force = -1;
      rand_rdy  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 11) == 0,
             RPC + 32'($urandom_range(0, 255)) * 32'd4,
             1'($urandom_range(0, 1)));
      end
      chk("rand_progress", 32'(n_deliv > 100), 32'h1);
      chk("rand_no_halt", 32'(halted), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
